// File: rtl/stage_pipe_sched_if.sv
// rtl/stage_pipe_sched_if.sv - handshake/datapath bundle between requesters, scheduler and capture/AND datapath
//
// Ports carried (WIDTH bits for operands/results, 1 bit otherwise):
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 operand pair handshake
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 operand pair handshake
//   dp_in1/dp_in2/dp_en1/dp_en2/dp_out  : datapath operands, capture enables, stage-2 result
//   rsp_valid/rsp_ready/rsp_id/rsp_data : in-order result handshake with owner tag
//   flush/flush_done/busy               : drain handshake and occupancy
// slave  = the scheduler; master = everything around it (requesters, datapath, consumer).
interface stage_pipe_sched_if #(
    parameter int WIDTH = 1
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic [WIDTH-1:0] dp_in1;
    logic [WIDTH-1:0] dp_in2;
    logic             dp_en1;
    logic             dp_en2;
    logic [WIDTH-1:0] dp_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             flush;
    logic             flush_done;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output dp_in1, dp_in2, dp_en1, dp_en2,
        input  dp_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        input  flush,
        output flush_done, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  dp_in1, dp_in2, dp_en1, dp_en2,
        output dp_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        output flush,
        input  flush_done, busy
    );
endinterface

// File: rtl/stage_pipe_sched.sv
// rtl/stage_pipe_sched.sv - two-requester scheduler for the two-stage capture/AND datapath
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; discards in-flight operations
//   bus  : stage_pipe_sched_if.slave (requests, datapath enables/operands, results, flush)
// Build option:
//   STAGE_PIPE_SCHED_RR_EN defined   -> round-robin between requesters on conflict
//   STAGE_PIPE_SCHED_RR_EN undefined -> requester 0 always wins a conflict
module stage_pipe_sched #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    stage_pipe_sched_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-stage occupancy and owner tags.
    logic v1;
    logic v2;
    logic t1;
    logic t2;

    logic adv1;
    logic adv2;
    logic en1;
    logic en2;
    logic eligible;
    logic win;
    logic grant0;
    logic grant1;
    logic rsp_fire;

    // Stage 2 can take new data when empty or when its result leaves this cycle;
    // stage 1 can take new data when empty or when it moves into stage 2.
    assign adv2     = !v2 | bus.rsp_ready;
    assign en2      = v1 & adv2;
    assign adv1     = !v1 | en2;
    assign rsp_fire = v2 & bus.rsp_ready;

    // rst is folded in so the readies drop the moment reset asserts.
    assign eligible = (state == ST_RUN) & !bus.flush & adv1 & !rst;

`ifdef STAGE_PIPE_SCHED_RR_EN
    // Requester that most recently completed a handshake; 1 out of reset so
    // requester 0 wins the first conflict.
    logic last;

    // On conflict the requester other than last wins.
    assign win = bus.req1_valid & (!bus.req0_valid | !last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (en1) begin
            last <= win;
        end
    end
`else
    assign win = bus.req1_valid & !bus.req0_valid;
`endif

    assign grant0 = eligible & bus.req0_valid & !win;
    assign grant1 = eligible & bus.req1_valid & win;
    assign en1    = grant0 | grant1;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.dp_en1     = en1;
    assign bus.dp_en2     = en2;

    // Requester-0 operands are presented whenever requester 1 is not granted.
    assign bus.dp_in1 = rst ? '0 : (grant1 ? bus.req1_a : bus.req0_a);
    assign bus.dp_in2 = rst ? '0 : (grant1 ? bus.req1_b : bus.req0_b);

    assign bus.rsp_valid  = v2;
    assign bus.rsp_id     = t2;
    assign bus.rsp_data   = bus.dp_out;
    assign bus.busy       = v1 | v2;
    assign bus.flush_done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            t1 <= 1'b0;
            t2 <= 1'b0;
        end else begin
            v1 <= en1 | (v1 & !en2);
            v2 <= en2 | (v2 & !rsp_fire);
            if (en1) begin
                t1 <= win;
            end
            if (en2) begin
                t2 <= t1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // The datapath keeps advancing during DRAIN; only new acceptances stop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (bus.flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.flush) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_stage_pipe_sched.sv
// tb/tb_stage_pipe_sched.sv - self-checking bench for stage_pipe_sched with a datapath model and scoreboard
module tb_stage_pipe_sched;

    localparam int W = 4;
`ifdef STAGE_PIPE_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    stage_pipe_sched_if #(.WIDTH(W)) bus ();

    stage_pipe_sched #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Datapath: unreset capture registers feeding an AND into stage 2.
    logic [W-1:0] dp_q1 = '0;
    logic [W-1:0] dp_q2 = '0;
    logic [W-1:0] dp_q  = '0;
    assign bus.dp_out = dp_q;
    always @(posedge clk) begin
        if (bus.dp_en1) begin
            dp_q1 <= bus.dp_in1;
            dp_q2 <= bus.dp_in2;
        end
        if (bus.dp_en2) begin
            dp_q <= dp_q1 & dp_q2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted pair is queued with its owner and a&b;
    // results must leave in the same order.
    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   last_m = 1'b1;

    always @(posedge rst) begin
        q.delete();
        last_m = 1'b1;
    end

    always @(negedge clk) begin
        ent_t e;
        bit   got;
        bit   expw;
        if (rst) begin
            q.delete();
            last_m = 1'b1;
        end else begin
            chk("busy_vs_inflight", bus.busy, q.size() != 0);
            chk("rsp_data_is_dp_out", bus.rsp_data, bus.dp_out);
            chk("dp_en1_vs_readies", bus.dp_en1, bus.req0_ready | bus.req1_ready);
            chk("single_ready", bus.req0_ready & bus.req1_ready, 1'b0);
            if (bus.flush) begin
                chk("flush_masks_ready", bus.req0_ready | bus.req1_ready, 1'b0);
            end
            if (q.size() == 2 && !bus.rsp_ready) begin
                chk("full_stall_en1", bus.dp_en1, 1'b0);
                chk("full_stall_en2", bus.dp_en2, 1'b0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_has_entry", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_id_order", bus.rsp_id, e.id);
                    chk("rsp_data_order", bus.rsp_data, e.data);
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                got = bus.req1_ready;
                if (bus.req0_valid && bus.req1_valid) begin
                    expw = RR ? !last_m : 1'b0;
                end else begin
                    expw = bus.req1_valid;
                end
                chk("winner", got, expw);
                chk("ready_needs_valid", got ? bus.req1_valid : bus.req0_valid, 1'b1);
                e.id   = got;
                e.data = got ? (bus.req1_a & bus.req1_b) : (bus.req0_a & bus.req0_b);
                q.push_back(e);
                last_m = got;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b1;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit exp_g[4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_g[i] = RR ? bit'(i % 2) : 1'b0;
        end

        // Reset state, with a request pending to prove readies and dp_in are held low.
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'hF;
        bus.req0_b     = 4'hF;
        smp();
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_flush_done", bus.flush_done, 1'b0);
        chk("rst_dp_en1", bus.dp_en1, 1'b0);
        chk("rst_dp_in1", bus.dp_in1, 4'h0);

        // Single operation latency.
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.req0_a = 4'h1;
        bus.req0_b = 4'h1;
        smp();
        chk("t1_c0_req0_ready", bus.req0_ready, 1'b1);
        chk("t1_c0_dp_in1", bus.dp_in1, 4'h1);
        cyc();
        bus.req0_valid = 1'b0;
        smp();
        chk("t1_c1_dp_en2", bus.dp_en2, 1'b1);
        chk("t1_c1_rsp_valid", bus.rsp_valid, 1'b0);
        cyc();
        smp();
        chk("t1_c2_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t1_c2_rsp_id", bus.rsp_id, 1'b0);
        chk("t1_c2_rsp_data", bus.rsp_data, 4'h1);
        cyc();
        smp();
        chk("t1_c3_busy", bus.busy, 1'b0);

        // Both requesters streaming; also the WIDTH=4 AND case 1100&1010=1000.
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'b1100;
        bus.req0_b     = 4'b1010;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 4'b1111;
        bus.req1_b     = 4'b0110;
        for (int k = 0; k < 6; k++) begin
            smp();
            if (k < 4) begin
                chk("t2_req0_ready", bus.req0_ready, !exp_g[k]);
                chk("t2_req1_ready", bus.req1_ready, exp_g[k]);
            end
            if (k >= 2) begin
                chk("t2_rsp_valid", bus.rsp_valid, 1'b1);
                chk("t2_rsp_id", bus.rsp_id, exp_g[k-2]);
                chk("t2_rsp_data", bus.rsp_data, exp_g[k-2] ? 4'b0110 : 4'b1000);
            end
            cyc();
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end

        // Fill the pipeline with rsp_ready low, hold three cycles, then drain.
        do_reset();
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'b0011;
        bus.req0_b     = 4'b0001;
        smp();
        chk("t3_acc0", bus.req0_ready, 1'b1);
        cyc();
        bus.req0_a = 4'b0110;
        bus.req0_b = 4'b0110;
        smp();
        chk("t3_acc1", bus.req0_ready, 1'b1);
        cyc();
        bus.req0_a = 4'b1111;
        bus.req0_b = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("t3_hold_en1", bus.dp_en1, 1'b0);
            chk("t3_hold_en2", bus.dp_en2, 1'b0);
            chk("t3_hold_ready", bus.req0_ready, 1'b0);
            chk("t3_hold_valid", bus.rsp_valid, 1'b1);
            chk("t3_hold_data", bus.rsp_data, 4'b0001);
            cyc();
        end
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        smp();
        chk("t3_ret0_data", bus.rsp_data, 4'b0001);
        cyc();
        smp();
        chk("t3_ret1_valid", bus.rsp_valid, 1'b1);
        chk("t3_ret1_data", bus.rsp_data, 4'b0110);
        cyc();
        smp();
        chk("t3_empty_valid", bus.rsp_valid, 1'b0);

        // Flush with two operations in flight.
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'b0111;
        bus.req0_b     = 4'b0101;
        smp();
        chk("t4_acc0", bus.req0_ready, 1'b1);
        cyc();
        smp();
        chk("t4_acc1", bus.req0_ready, 1'b1);
        cyc();
        bus.flush = 1'b1;
        for (int k = 2; k < 6; k++) begin
            smp();
            chk("t4_drain_ready", bus.req0_ready, 1'b0);
            chk("t4_flush_done", bus.flush_done, k == 5);
            cyc();
        end
        bus.flush = 1'b0;
        smp();
        chk("t4_done_hold", bus.flush_done, 1'b1);
        chk("t4_done_ready", bus.req0_ready, 1'b0);
        cyc();
        smp();
        chk("t4_resume_done", bus.flush_done, 1'b0);
        chk("t4_resume_ready", bus.req0_ready, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        repeat (3) begin
            smp();
            cyc();
        end

        // Flush of an already-empty pipeline: DONE one cycle after entering DRAIN.
        bus.flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("t4e_flush_done", bus.flush_done, k == 2);
            cyc();
        end
        bus.flush = 1'b0;
        cyc();

        // Reset while both stages are full.
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'b1100;
        bus.req0_b     = 4'b1010;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 4'b1111;
        bus.req1_b     = 4'b0110;
        repeat (3) begin
            smp();
            cyc();
        end
        smp();
        chk("t5_pre_busy", bus.busy, 1'b1);
        chk("t5_pre_valid", bus.rsp_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", bus.rsp_valid, 1'b0);
        chk("t5_rst_busy", bus.busy, 1'b0);
        chk("t5_rst_req0_ready", bus.req0_ready, 1'b0);
        chk("t5_rst_req1_ready", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        smp();
        chk("t5_post_req0_ready", bus.req0_ready, 1'b1);
        chk("t5_post_req1_ready", bus.req1_ready, 1'b0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (3) begin
            smp();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_pipe_sched.md
# stage_pipe_sched

Scheduler that shares the two-stage capture/AND datapath (`blk_stage1` → `blk_stage2`) between two requesters. It arbitrates operand pairs onto the datapath, generates the stage-1 and stage-2 capture enables, and tags each operation with its owner. It returns results in order under a valid/ready handshake and supports a drain (flush) handshake. It sits directly above the datapath; the datapath registers load only when their enable is high.

## Interface

Parameters:
- `WIDTH`, default 1: operand/result width per lane.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req0_ready` out 1: requester 0 pair accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `dp_in1`, `dp_in2` out WIDTH: operands driven to stage-1 registers.
- `dp_en1` out 1: stage-1 capture enable.
- `dp_en2` out 1: stage-2 capture enable; stage 2 registers `AND(stage1_q1, stage1_q2)`.
- `dp_out` in WIDTH: stage-2 register output.
- `rsp_valid` out 1, `rsp_ready` in 1: result handshake.
- `rsp_id` out 1: owner of the current result.
- `rsp_data` out WIDTH: equals `dp_out`, combinational.
- `flush` in 1: drain request (level).
- `flush_done` out 1: pipeline is empty and the drain is acknowledged.
- `busy` out 1: `v1 | v2`.

## Operation

Internal state:
- Valid bits `v1` and `v2`, one per datapath stage.
- Tags `t1` and `t2`, the owner of each stage's contents.
- `last`, the last-granted requester.
- FSM state.

Pipeline advance, all combinational:
- `adv2 = !v2 | rsp_ready`
- `dp_en2 = v1 & adv2`
- `adv1 = !v1 | dp_en2`

Grant:
- A requester is eligible when the FSM is in RUN, `flush` is 0, and `adv1` is 1.
- Only one valid requester: it wins.
- Both valid: the requester ≠ `last` wins.
- `reqN_ready = eligible & granted N`; at most one ready is high per cycle.
- `dp_en1 = req0_ready | req1_ready`.
- `dp_in1`/`dp_in2` mux the winner's a/b; they hold the requester-0 operands when no grant is made.
- `last` updates only on an accepted handshake.

Stage update on each edge:
- `v1 <= dp_en1 | (v1 & !dp_en2)`; `t1` loads the winner id when `dp_en1` is high.
- `v2 <= dp_en2 | (v2 & !(rsp_valid & rsp_ready))`; `t2 <= t1` when `dp_en2` is high.

Outputs:
- `rsp_valid = v2`, `rsp_id = t2`.
- Results leave in acceptance order.
- While `rsp_ready` is low, the result and both stages hold, with `dp_en1` and `dp_en2` low as required.

FSM:
- RUN: on `flush=1` → DRAIN. Readies are masked in the same cycle `flush` rises.
- DRAIN: readies low; when `v1=0 & v2=0` → DONE. An already-empty pipeline reaches DONE one cycle after entering DRAIN.
- DONE: `flush_done=1` and readies low; stays while `flush=1`; → RUN when `flush=0`.

Reset values and mid-operation reset:
- Reset values: `v1=v2=0`, `t1=t2=0`, `last=1` (so requester 0 wins first), state RUN.
- All outputs reset low; `dp_in*` reset to 0.
- An asserted reset discards in-flight operations immediately.
- Datapath registers are not reset; their contents are ignored because the valid bits are cleared.

## Timing

- Latency: a pair accepted in cycle t has `dp_en2` in t+1 and `rsp_valid` in t+2, given `rsp_ready=1`.
- Throughput: one operation per cycle with `rsp_ready` held high.
- Simultaneous `rsp_ready` handshake and new acceptance with the pipeline full: allowed, and the pipeline stays full.
- `flush` rising in the same cycle as a valid request: the request is not accepted.
- `flush_done` is combinational from state; a 4-phase handshake with `flush`.

## Configuration

- `STAGE_PIPE_SCHED_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, requester 0 always wins a conflict; `last` is not implemented.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then `req0_valid=1`, `a=1`, `b=1`, `rsp_ready=1`: `req0_ready` in cycle 0, `rsp_valid=1`, `rsp_id=0`, `rsp_data=1` in cycle 2; `busy` low by cycle 3.
- Both requesters valid continuously with `rsp_ready=1` (RR build): grants alternate 0,1,0,1 and `rsp_id` follows 2 cycles later. Fixed-priority build: all grants go to 0.
- Pipeline full, `rsp_ready=0` for 3 cycles: `dp_en1`, `dp_en2` and both readies stay 0 and `rsp_data` is stable. After `rsp_ready=1`, one result retires per cycle with no loss or reordering.
- Two ops in flight, `flush=1`: no further readies; `flush_done=1` 3 cycles later after both results retire. Then `flush=0`: RUN resumes and accepts next cycle.
- `rst` asserted mid-stream with `v1=v2=1`: `rsp_valid`, `busy` and the readies drop immediately. After release, requester 0 wins the first conflict.
- WIDTH=4, operands `a=4'b1100`, `b=4'b1010`: `rsp_data=4'b1000`.
